// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the per-channel clock-gating controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_ON    = 2'b00,
        ST_COUNT = 2'b01,
        ST_OFF   = 2'b10,
        ST_WAKE  = 2'b11
    } ch_state_e;

    localparam int WAKE_CNT_W = 3;

endpackage

// File: rtl/clk_gate_ch_fsm.sv
// One gated-clock channel: ON/COUNT/OFF/WAKE sequencer with idle and wake counters.
module clk_gate_ch_fsm
    import clk_gate_pkg::*;
#(
    parameter int IDLE_W   = 4,
    parameter int WAKE_CYC = 2
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              active,
    input  logic              wake_req,
    input  logic [IDLE_W-1:0] idle_thresh,
    output logic              module_en,
    output logic              wake_ack,
    output logic              clk_on,
    output logic              is_off
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYC - 1);
    localparam logic [IDLE_W-1:0]     IDLE_ONE  = IDLE_W'(1);

    ch_state_e               state_reg, state_next;
    logic [IDLE_W-1:0]       idle_cnt_reg, idle_cnt_next;
    logic [WAKE_CNT_W-1:0]   wake_cnt_reg, wake_cnt_next;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_reg    <= ST_ON;
            idle_cnt_reg <= '0;
            wake_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            idle_cnt_reg <= idle_cnt_next;
            wake_cnt_reg <= wake_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idle_cnt_next = idle_cnt_reg;
        wake_cnt_next = wake_cnt_reg;
        unique case (state_reg)
            ST_ON: begin
                if (!active) begin
                    if (idle_thresh == '0) begin
                        state_next = ST_OFF;
                    end else begin
                        state_next    = ST_COUNT;
                        idle_cnt_next = idle_thresh;
                    end
                end
            end
            ST_COUNT: begin
                if (active) begin
                    state_next = ST_ON;
                end else if (idle_cnt_reg == IDLE_ONE) begin
                    state_next    = ST_OFF;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_reg - IDLE_ONE;
                end
            end
            ST_OFF: begin
                if (active) begin
                    state_next    = ST_WAKE;
                    wake_cnt_next = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Once started, a restart always runs to completion.
                if (wake_cnt_reg == '0) begin
                    state_next = ST_ON;
                end else begin
                    wake_cnt_next = wake_cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_ON;
        endcase
    end

    assign module_en = (state_reg != ST_OFF);
    assign clk_on    = (state_reg != ST_OFF);
    assign is_off    = (state_reg == ST_OFF);
    // COUNT acknowledges at once since the clock never stopped.
    assign wake_ack  = wake_req & ((state_reg == ST_COUNT) |
                                   ((state_reg == ST_WAKE) && (wake_cnt_reg == '0)));

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller top: active-term decode, per-channel FSMs, scan override, idle summary.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 4,
    parameter int WAKE_CYC = 2
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              cfg_gate_en,
    input  logic [IDLE_W-1:0] cfg_idle_thresh,
    input  logic [NUM_CH-1:0] cfg_force_on,
    input  logic [NUM_CH-1:0] ch_busy,
    input  logic [NUM_CH-1:0] ch_wake_req,
    input  logic              pad_yy_icg_scan_en,
    output logic [NUM_CH-1:0] ch_module_en,
    output logic [NUM_CH-1:0] ch_wake_ack,
    output logic [NUM_CH-1:0] ch_clk_on,
    output logic              all_idle
);

    logic [NUM_CH-1:0] ch_active;
    logic [NUM_CH-1:0] fsm_en;
    logic [NUM_CH-1:0] ch_off;

    assign ch_active = ch_busy | ch_wake_req | cfg_force_on | {NUM_CH{~cfg_gate_en}};

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clk_gate_ch_fsm #(
                .IDLE_W   (IDLE_W),
                .WAKE_CYC (WAKE_CYC)
            ) u_fsm (
                .forever_cpuclk (forever_cpuclk),
                .cpurst_b       (cpurst_b),
                .active         (ch_active[gi]),
                .wake_req       (ch_wake_req[gi]),
                .idle_thresh    (cfg_idle_thresh),
                .module_en      (fsm_en[gi]),
                .wake_ack       (ch_wake_ack[gi]),
                .clk_on         (ch_clk_on[gi]),
                .is_off         (ch_off[gi])
            );
        end
    endgenerate

    // Scan overrides the enables only; FSM state is untouched.
    assign ch_module_en = fsm_en | {NUM_CH{pad_yy_icg_scan_en}};
    assign all_idle     = &ch_off;

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Per-channel clock-gating controller that sequences the `module_en` inputs of a bank of gated clock cells. It watches each channel's busy and wake-request signals, turns a channel's clock off after a programmable idle time, and restarts it with a fixed settle delay and a wake acknowledge. It sits in the clock/reset domain block, between the functional units' status outputs and their gated clock cells.

## Interface
Parameters:
- `NUM_CH`, 4: number of gated channels.
- `IDLE_W`, 4: width of the idle threshold and counter.
- `WAKE_CYC`, 2: cycles the clock is enabled before `wake_ack` (1..7).

Ports:
- `forever_cpuclk`  in  1  free-running clock; reset is asynchronous and active-low.
- `cpurst_b`  in  1  asynchronous reset, active low.
- `cfg_gate_en`  in  1  0 = gating disabled: all channels held ON.
- `cfg_idle_thresh`  in  IDLE_W  idle cycles before gating, sampled on ON→COUNT entry.
- `cfg_force_on`  in  NUM_CH  per-channel force-on.
- `ch_busy`  in  NUM_CH  channel has work in flight, level.
- `ch_wake_req`  in  NUM_CH  request clock restart, level, held until `wake_ack`.
- `pad_yy_icg_scan_en`  in  1  scan mode: forces all `ch_module_en` high combinationally.
- `ch_module_en`  out  NUM_CH  to gated clock cell `module_en`.
- `ch_wake_ack`  out  NUM_CH  one-cycle pulse: channel clock is stable.
- `ch_clk_on`  out  NUM_CH  status: channel state is not OFF.
- `all_idle`  out  1  every channel is in OFF.

## Operation
- Each channel runs an independent FSM with states ON, COUNT, OFF, WAKE. Reset state is ON, idle counter 0, wake counter 0.
- A channel is **active** when `ch_busy | ch_wake_req | cfg_force_on | ~cfg_gate_en` is true for that channel.
- ON: `module_en`=1.
  - Active → stay in ON.
  - Not active and `cfg_idle_thresh`==0 → OFF.
  - Otherwise → COUNT, with counter loaded with `cfg_idle_thresh`.
- COUNT: `module_en`=1.
  - Active → ON (wake_req in COUNT gives an immediate `wake_ack` that same cycle, with no restart delay).
  - Otherwise decrement; counter==1 → OFF.
- OFF: `module_en`=0. Active → WAKE with wake counter=`WAKE_CYC`-1.
- WAKE: `module_en`=1. Counter==0 → ON and pulse `wake_ack`; otherwise decrement. Busy/wake_req deassertion during WAKE does not abort it.
- `ch_wake_ack` is asserted only while `ch_wake_req` is high. A WAKE entered by busy or force-on alone completes silently.
- `ch_module_en` = FSM value | `pad_yy_icg_scan_en`. Scan does not change FSM state.
- Threshold changes take effect only on the next COUNT entry.
- `all_idle` = AND of (state==OFF) across channels. It is registered-state derived, with no combinational input path.

## Timing
- All outputs are decoded from registered state, except the scan OR term and `wake_ack` in COUNT. `wake_ack` in COUNT is state & `ch_wake_req`, which is combinational from the input.
- Reset values: `ch_module_en`=all 1, `ch_clk_on`=all 1, `ch_wake_ack`=0, `all_idle`=0.
- Gating latency: the last busy cycle is N. With threshold T>0, `module_en` falls at the edge ending cycle N+T+1. With T=0, it falls at N+1.
- Wake latency: request seen in OFF at cycle N. `module_en` rises after edge N. `wake_ack` is high in cycle N+WAKE_CYC. State is ON from N+WAKE_CYC+1.
- Reset asserted mid-operation returns every channel to ON within zero clocks (asynchronous). Outputs take their reset values immediately.
- `cfg_gate_en` falling has the following effect:
  - OFF channels go through WAKE normally.
  - COUNT channels return to ON next cycle.

## Structure
- Package `clk_gate_pkg` contains:
  - State enum: ON=2'b00, COUNT=2'b01, OFF=2'b10, WAKE=2'b11.
  - `WAKE_CNT_W`=3.
- Sub-module `clk_gate_ch_fsm` holds one channel (FSM, idle counter, wake counter). It is instantiated `NUM_CH` times in a generate loop.
- The top level holds the active-term computation, scan OR, and `all_idle` reduction.

## Test plan
- Reset, then idle with thresh=3: `module_en[0]` stays 1 for 4 cycles after reset release, then 0. `all_idle`=1 once all four channels reach OFF.
- Channel 1 in OFF, `wake_req[1]` raised at cycle 10 with `WAKE_CYC`=2: `module_en[1]`=1 from cycle 11. `wake_ack[1]` pulses in cycle 12 only. `ch_clk_on[1]`=1 from cycle 11.
- thresh=5, busy drops then returns after 3 cycles: no gating. Counter reloads with 5 on the next idle.
- thresh=0: `module_en` falls the cycle after busy drops. `cfg_gate_en`=0 keeps all channels ON indefinitely with busy=0.
- `pad_yy_icg_scan_en`=1 while channels are OFF: all `ch_module_en`=1 immediately, `all_idle` stays 1. On scan release, `ch_module_en` returns to 0.
- `cpurst_b` pulsed low during WAKE of channel 2: all outputs take reset values asynchronously, and no `wake_ack` appears after reset release.
